// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for six requesters sharing one output channel. Each grant
// is capped at MAX_BURST transfers and the next grantee takes over without a bubble.
module rr_mux_arbiter #(
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4    // legal range 1..15, sized for the 4-bit burst counter
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    input  logic [DATA_W-1:0] data4,
    input  logic [DATA_W-1:0] data5,
    input  logic              out_ready,
    output logic [5:0]        gnt,
    output logic [2:0]        sel,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q;
    logic [5:0]  gnt_q;
    logic [2:0]  sel_q;
    logic [2:0]  ptr_q;
    logic [3:0]  cnt_q;

    logic [DATA_W-1:0] data_sel;
    logic              xfer;
    logic              grant_end;
    logic [2:0]        ptr_nxt;
    logic [3:0]        win_idle;
    logic [3:0]        win_hand;

    // Returns {found, index}. Scanning from the farthest offset down lets the
    // nearest requester to the pointer overwrite the result last.
    function automatic logic [3:0] arbitrate(input logic [5:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int k = 5; k >= 0; k--) begin
            idx = 3'((int'(p) + k) % 6);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        data_sel = '0;
        case (sel_q)
            3'd0:    data_sel = data0;
            3'd1:    data_sel = data1;
            3'd2:    data_sel = data2;
            3'd3:    data_sel = data3;
            3'd4:    data_sel = data4;
            3'd5:    data_sel = data5;
            default: data_sel = '0;
        endcase
    end

    assign out_valid = (state_q == GRANT) && req[sel_q];
    assign out       = out_valid ? data_sel : '0;
    assign xfer      = out_valid && out_ready;
    assign grant_end = !req[sel_q] || (xfer && (cnt_q == 4'(MAX_BURST - 1)));
    assign ptr_nxt   = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
    assign win_idle  = arbitrate(req, ptr_q);
    assign win_hand  = arbitrate(req, ptr_nxt);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_idle[3]) begin
                        sel_q   <= win_idle[2:0];
                        gnt_q   <= 6'(1) << win_idle[2:0];
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        ptr_q <= ptr_nxt;
                        if (win_hand[3]) begin
                            sel_q <= win_hand[2:0];
                            gnt_q <= 6'(1) << win_hand[2:0];
                            cnt_q <= '0;
                        end else begin
                            gnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end else if (xfer) begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a transaction-level model.
module tb_rr_mux_arbiter;

    localparam int DATA_W    = 4;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [5:0]        req;
    logic [DATA_W-1:0] d [6];
    logic              out_ready;
    logic [5:0]        gnt;
    logic [2:0]        sel;
    logic [DATA_W-1:0] dut_out;
    logic              out_valid;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: who owns the channel (-1 when nobody), last select shown,
    // round-robin start point and transfers completed in the current grant.
    int m_owner, m_sel, m_prio, m_served;

    rr_mux_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .req(req),
        .data0(d[0]), .data1(d[1]), .data2(d[2]),
        .data3(d[3]), .data4(d[4]), .data5(d[5]),
        .out_ready(out_ready), .gnt(gnt), .sel(sel), .out(dut_out),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [5:0] r, input int start);
        for (int k = 0; k < 6; k++) begin
            if (r[(start + k) % 6]) return (start + k) % 6;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        if (reset) begin
            m_owner  = -1;
            m_sel    = 0;
            m_prio   = 0;
            m_served = 0;
        end else if (m_owner < 0) begin
            w = pick(req, m_prio);
            if (w >= 0) begin
                m_owner  = w;
                m_sel    = w;
                m_served = 0;
            end
        end else begin
            if (req[m_owner] && out_ready) m_served++;
            if (!req[m_owner] || m_served == MAX_BURST) begin
                m_prio = (m_owner + 1) % 6;
                w = pick(req, m_prio);
                m_owner = w;
                if (w >= 0) begin
                    m_sel    = w;
                    m_served = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic            exp_valid;
        logic [DATA_W-1:0] exp_out;
        if (chk_en) begin
            exp_valid = (m_owner >= 0) ? req[m_owner] : 1'b0;
            exp_out   = exp_valid ? d[m_owner] : '0;
            check("model_gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("model_sel", 32'(sel), 32'(m_sel));
            check("model_valid", 32'(out_valid), 32'(exp_valid));
            check("model_out", 32'(dut_out), 32'(exp_out));
            check("model_busy", 32'(busy), 32'(m_owner >= 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = 6'h3F;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) d[i] = DATA_W'(i + 1);

        // Reset held two cycles with everyone requesting
        tick();
        chk_en = 1'b1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(dut_out), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rel_gnt", 32'(gnt), 32'h01);
        check("rel_sel", 32'(sel), 32'd0);

        // All requesting: each select held for exactly MAX_BURST cycles
        for (int k = 0; k < 25; k++) begin
            if (k > 0) tick();
            check("rot_sel", 32'(sel), 32'((k / 4) % 6));
            check("rot_onehot", 32'($onehot(gnt)), 32'd1);
        end

        // Single requester: continuous stream with no bubble at re-grant
        do_reset();
        req  = 6'b000100;
        d[2] = 4'hA;
        tick();
        check("single_sel", 32'(sel), 32'd2);
        check("single_gnt", 32'(gnt), 32'h04);
        for (int k = 0; k < 12; k++) begin
            check("single_valid", 32'(out_valid), 32'd1);
            check("single_out", 32'(dut_out), 32'hA);
            tick();
        end

        // Backpressure on requester 1, requester 2 waiting
        do_reset();
        req = 6'b000110;
        tick();
        check("bp_sel", 32'(sel), 32'd1);
        tick();
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_sel", 32'(sel), 32'd1);
            check("bp_hold_gnt", 32'(gnt), 32'h02);
        end
        out_ready = 1'b1;
        tick();
        check("bp_third_sel", 32'(sel), 32'd1);
        tick();
        check("bp_rotate_sel", 32'(sel), 32'd2);

        // Early release of requester 3 with requester 5 waiting
        do_reset();
        req = 6'b101000;
        tick();
        check("early_sel", 32'(sel), 32'd3);
        tick();
        tick();
        req = 6'b100000;
        #1;
        check("early_drop_valid", 32'(out_valid), 32'd0);
        tick();
        check("early_next_sel", 32'(sel), 32'd5);
        check("early_next_out", 32'(dut_out), 32'(d[5]));

        // Reset during requester 4's third transfer
        do_reset();
        req = 6'b010000;
        tick();
        tick();
        tick();
        check("mid_sel", 32'(sel), 32'd4);
        reset = 1'b1;
        tick();
        check("mid_gnt", 32'(gnt), 32'd0);
        check("mid_sel_rst", 32'(sel), 32'd0);
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        req   = 6'h3F;
        tick();
        check("mid_regrant_sel", 32'(sel), 32'd0);
        check("mid_regrant_gnt", 32'(gnt), 32'h01);

        // Random traffic, checked by the model only
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) req = 6'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 6; i++) d[i] = DATA_W'($urandom);
            tick();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer for the shared 6-input, 4-bit select datapath. Six requesters compete for a single output channel. The block grants one requester at a time, drives the 3-bit select, and streams the granted requester's data downstream under a valid/ready handshake. Each grant is capped at a burst limit so no requester can starve the others.

## Interface
- `DATA_W`, default 4: width of each data input and of `out`.
- `MAX_BURST`, default 4: maximum transfers per grant. Legal range is 1..15.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  6: `req[i]` asserted while requester i has data; held until requester i sees its grant end.
- `data0`..`data5`  in  `DATA_W` each: requester payloads; `data[i]` is valid while `req[i]` is high.
- `out_ready`  in  1: downstream accepts `out` this cycle.
- `gnt`  out  6: one-hot registered grant; all zero when idle.
- `sel`  out  3: registered select, values 0..5 only; never 6 or 7.
- `out`  out  `DATA_W`: the selected data when `out_valid` is high, otherwise 0.
- `out_valid`  out  1: a transfer is offered this cycle.
- `busy`  out  1: the FSM is in GRANT.

## Operation
- FSM states: IDLE and GRANT.
- Registers: `state`, `sel`, `gnt`, rotating priority pointer `ptr` (0..5), burst counter `cnt` (4 bits).
- Arbitration function: the winner is the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, … modulo 6. The result is "none" if `req`=0.
- IDLE:
  - If a winner w exists, load `sel`=w, `gnt`=1<<w, `cnt`=0, and go to GRANT.
  - Otherwise remain in IDLE.
- GRANT:
  - `out_valid` = `req[sel]`, combinational from registered `sel` and live `req`.
  - `out` = `data[sel]` when `out_valid`, else 0.
  - A transfer occurs on a cycle with `out_valid`=1 and `out_ready`=1. It increments `cnt`.
- Grant end, evaluated at each edge in GRANT, is the first true of:
  - (a) `req[sel]`=0.
  - (b) a transfer occurs with `cnt`=`MAX_BURST`-1.
- On grant end:
  - Set `ptr`=(`sel`+1) mod 6, so the just-served requester gets lowest priority.
  - Re-run arbitration with this new pointer in the same cycle.
  - If there is a winner, load the new `sel`/`gnt`, set `cnt`=0, and stay in GRANT. There is no bubble.
  - If there is no winner, go to IDLE with `gnt`=0 and `sel` retaining its old value.
- A lone requester that hits `MAX_BURST` is re-granted immediately. Its `cnt` restarts at 0 and it sees no bubble.
- Backpressure: while `out_ready`=0, `cnt`, `sel` and `gnt` hold. The grant persists indefinitely unless `req[sel]` drops.
- Requests from non-granted requesters never affect `sel` or `out` during a grant.
- `cnt` saturates logically at `MAX_BURST`-1, because reaching the limit always ends the grant.

## Timing
- Reset values: `state`=IDLE, `gnt`=0, `sel`=0, `ptr`=0, `cnt`=0, `out_valid`=0, `out`=0, `busy`=0.
- Reset asserted mid-burst:
  - The next edge forces the reset values.
  - Any transfer offered in that cycle still completes combinationally, but the counter effect is discarded.
- Grant latency: `req` first sampled high at edge k in IDLE gives `gnt`/`sel`/`busy` valid after edge k. The first `out_valid` can appear in cycle k+1.
- Handover latency: the grant ends at edge k, and the new grantee's data is on `out` in the cycle after edge k.
- `out_valid` falls in the same cycle `req[sel]` falls. The grant is released at the following edge.
- Simultaneous grant end by (a) and (b): treated as one grant end, with identical behaviour.
- Throughput: up to 1 transfer per cycle, including across handovers.

## Test plan
- **Reset:** pulse `reset` for 2 cycles with `req`=6'h3F. Required: `gnt`=0, `sel`=0, `out`=0, `out_valid`=0 during reset. The cycle after release gives `gnt`=6'b000001, `sel`=0.
- **Single requester:** `req`=6'b000100, `data2`=4'hA, `out_ready`=1, `MAX_BURST`=4. Required: `sel`=2 one cycle after the request; `out`=4'hA with `out_valid`=1 every cycle continuously; `cnt` wraps 0→3→0 with no bubble.
- **All requesting:** `req`=6'h3F, `out_ready`=1. Required: `sel` sequence 0,1,2,3,4,5,0, each held for exactly 4 cycles; `gnt` always one-hot.
- **Backpressure:** requester 1 granted; `out_ready` low for 5 cycles after 2 transfers. Required: `sel`=1 held through the stall. Exactly 2 more transfers follow once ready returns, then rotation to the next requester.
- **Early release:** requesters 3 and 5 active; `req[3]` dropped after 2 transfers. Required: `out_valid` drops the same cycle; `sel`=5 from the next cycle.
- **Mid-burst reset:** `reset` asserted during requester 4's 3rd transfer. Required: all outputs at reset values the next cycle. After release with `req`=6'h3F, the grant goes to requester 0 because `ptr` is reset.
